usb_fifo_bridge: RTL and testbench

//  FX2LP (CY68013) slave-FIFO master. Sits between the USB chip pins and the picorv32 SoC fabric.

---
 rtl/usb_fifo_bridge.sv | 131 +++++++++++++
 tb/tb_usb_fifo_bridge.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_fifo_bridge.sv
// usb_fifo_bridge: FX2LP slave-FIFO master draining EP2 into an RX word FIFO and filling EP6 from a TX word FIFO
module usb_fifo_bridge #(
  parameter int RX_DEPTH   = 16,
  parameter int TX_DEPTH   = 16,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      usb_flaga,
  input  logic                      usb_flagc,
  output logic                      usb_slcs,
  output logic                      usb_slrd,
  output logic                      usb_slwr,
  output logic                      usb_sloe,
  output logic                      usb_pktend,
  output logic [1:0]                usb_fifoaddr,
  inout  wire  [15:0]               usb_fd,
  output logic [15:0]               rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  input  logic [15:0]               tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  input  logic                      tx_flush,
  output logic [$clog2(RX_DEPTH):0] rx_level,
  output logic [$clog2(TX_DEPTH):0] tx_level
);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TAW = $clog2(TX_DEPTH);
  typedef enum logic [3:0] {IDLE, RD_SETUP, RD_STROBE, RD_HOLD, WR_SETUP, WR_STROBE, WR_HOLD, PE_SETUP, PE_STROBE} state_t;
  state_t state;
  logic [7:0] cnt, lim;
  logic last, fd_oe, flush_pend, last_wr, rd_ok, wr_ok, pe_ok, rx_push, rx_pop, tx_push, tx_pop;
  logic [15:0] fd_q;
  logic [15:0] rx_mem [RX_DEPTH];
  logic [15:0] tx_mem [TX_DEPTH];
  logic [RAW-1:0] rx_wp, rx_rp;
  logic [TAW-1:0] tx_wp, tx_rp;
  assign usb_slcs = 1'b0;
  assign usb_fd   = fd_oe ? fd_q : 16'bz;
  assign rx_valid = rx_level != '0;
  assign rx_data  = rx_mem[rx_rp];
  assign tx_ready = tx_level != (TAW+1)'(TX_DEPTH);
  always_comb begin
    lim = (state == RD_SETUP || state == WR_SETUP || state == PE_SETUP) ? 8'(SETUP_CYC)
        : (state == RD_STROBE || state == WR_STROBE || state == PE_STROBE) ? 8'(STROBE_CYC) : 8'(HOLD_CYC);
    last    = cnt == lim - 8'd1;
    rd_ok   = usb_flaga && rx_level <= (RAW+1)'(RX_DEPTH - 1);
    wr_ok   = usb_flagc && tx_level != '0;
    pe_ok   = flush_pend && tx_level == '0 && usb_flagc;
    rx_push = state == RD_STROBE && last && rx_level != (RAW+1)'(RX_DEPTH);
    rx_pop  = rx_valid && rx_ready;
    tx_push = tx_valid && tx_ready;
    tx_pop  = state == WR_STROBE && last;
  end
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= usb_fd;
    if (tx_push) tx_mem[tx_wp] <= tx_data;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_level <= '0;
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_level <= '0;
    end else begin
      rx_wp    <= rx_wp + RAW'(rx_push);
      rx_rp    <= rx_rp + RAW'(rx_pop);
      rx_level <= rx_level + (RAW+1)'(rx_push) - (RAW+1)'(rx_pop);
      tx_wp    <= tx_wp + TAW'(tx_push);
      tx_rp    <= tx_rp + TAW'(tx_pop);
      tx_level <= tx_level + (TAW+1)'(tx_push) - (TAW+1)'(tx_pop);
    end
  end
  // last_wr resets high so the first read/write tie goes to the read side
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      usb_slrd     <= 1'b1;
      usb_slwr     <= 1'b1;
      usb_sloe     <= 1'b1;
      usb_pktend   <= 1'b1;
      usb_fifoaddr <= 2'b00;
      fd_oe        <= 1'b0;
      fd_q         <= '0;
      flush_pend   <= 1'b0;
      last_wr      <= 1'b1;
    end else begin
      flush_pend <= (state == PE_STROBE && last) ? 1'b0 : flush_pend | tx_flush;
      cnt        <= (state == IDLE || last) ? '0 : cnt + 8'd1;
      case (state)
        IDLE:
          if (pe_ok) begin
            state        <= PE_SETUP;
            usb_fifoaddr <= 2'b10;
          end else if (rd_ok && (!wr_ok || last_wr)) begin
            state        <= RD_SETUP;
            usb_fifoaddr <= 2'b00;
            usb_sloe     <= 1'b0;
            last_wr      <= 1'b0;
          end else if (wr_ok) begin
            state        <= WR_SETUP;
            usb_fifoaddr <= 2'b10;
            fd_oe        <= 1'b1;
            fd_q         <= tx_mem[tx_rp];
            last_wr      <= 1'b1;
          end
        RD_SETUP:  if (last) begin state <= RD_STROBE; usb_slrd <= 1'b0; end
        RD_STROBE: if (last) begin state <= RD_HOLD; usb_slrd <= 1'b1; end
        RD_HOLD: begin
          if (cnt == '0) usb_sloe <= 1'b1;
          if (last) state <= IDLE;
        end
        WR_SETUP:  if (last) begin state <= WR_STROBE; usb_slwr <= 1'b0; end
        WR_STROBE: if (last) begin state <= WR_HOLD; usb_slwr <= 1'b1; end
        WR_HOLD: begin
          if (cnt == '0) fd_oe <= 1'b0;
          if (last) state <= IDLE;
        end
        PE_SETUP:  if (last) begin state <= PE_STROBE; usb_pktend <= 1'b0; end
        PE_STROBE: if (last) begin state <= IDLE; usb_pktend <= 1'b1; end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_usb_fifo_bridge.sv
// tb_usb_fifo_bridge: FX2 pin model plus queue-level model of both word FIFOs, checked every cycle
module tb_usb_fifo_bridge;
  localparam int D = 16;
  logic clk = 0, reset = 1, usb_flagc = 0, rx_ready = 0, tx_valid = 0, tx_flush = 0;
  logic [15:0] tx_data = 0;
  logic usb_slcs, usb_slrd, usb_slwr, usb_sloe, usb_pktend, rx_valid, tx_ready, usb_flaga;
  logic [1:0] usb_fifoaddr;
  logic [15:0] rx_data;
  logic [4:0] rx_level, tx_level;
  wire [15:0] usb_fd;
  logic [15:0] ep2_mem [0:31];
  int ep2_n = 0, ep2_rd = 0;
  int checks = 0, failures = 0;
  logic [15:0] m_rx[$], m_tx[$], rx_popped[$], ep6[$];
  int rd_run = 0, wr_run = 0, pe_run = 0, rd_cnt = 0, wr_cnt = 0, pe_cnt = 0;
  int last_rd_len = 0, last_pe_len = 0, quiet = 8;
  bit tx_room, drv, prev_drv = 0;
  string serve = "";

  // FX2 side: EP2 data on the bus whenever the bridge asserts SLOE, otherwise pulled up
  assign usb_flaga = ep2_rd < ep2_n;
  assign usb_fd = usb_sloe ? 16'bz : ep2_mem[ep2_rd];
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (usb_fd[i]);
  end
  always #10 clk = ~clk;

  usb_fifo_bridge dut (
    .clk(clk), .reset(reset), .usb_flaga(usb_flaga), .usb_flagc(usb_flagc),
    .usb_slcs(usb_slcs), .usb_slrd(usb_slrd), .usb_slwr(usb_slwr), .usb_sloe(usb_sloe),
    .usb_pktend(usb_pktend), .usb_fifoaddr(usb_fifoaddr), .usb_fd(usb_fd),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_flush(tx_flush),
    .rx_level(rx_level), .tx_level(tx_level)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%s required=%s", name, act, exp);
    end
  endtask

  // Transfer model: a word moves on the 4th sampled low cycle of its strobe
  always @(posedge clk) begin
    if (reset) begin
      m_rx.delete(); m_tx.delete(); rx_popped.delete(); ep6.delete();
      rd_run = 0; wr_run = 0; pe_run = 0; rd_cnt = 0; wr_cnt = 0; pe_cnt = 0;
      serve = "";
      ep2_rd <= 0;
    end else begin
      tx_room = m_tx.size() < D;
      if (rx_valid && rx_ready) rx_popped.push_back(rx_data);
      if (rx_ready && m_rx.size() > 0) void'(m_rx.pop_front());
      if (!usb_slrd) begin
        chk("rd_addr", 32'(usb_fifoaddr), 0);
        rd_run++;
        if (rd_run == 4) begin
          m_rx.push_back(ep2_mem[ep2_rd]);
          ep2_rd <= ep2_rd + 1;
          rd_cnt++;
          serve = {serve, "R"};
        end
      end else if (rd_run != 0) begin
        chk("rd_strobe_len", rd_run, 4);
        last_rd_len = rd_run;
        rd_run = 0;
      end
      if (!usb_slwr) begin
        chk("wr_addr", 32'(usb_fifoaddr), 2);
        wr_run++;
        if (wr_run == 4) begin
          chk("ep6_expected", 32'(m_tx.size() != 0), 1);
          if (m_tx.size() != 0) begin
            chk("ep6_word", 32'(usb_fd), 32'(m_tx[0]));
            void'(m_tx.pop_front());
          end
          ep6.push_back(usb_fd);
          wr_cnt++;
          serve = {serve, "W"};
        end
      end else if (wr_run != 0) begin
        chk("wr_strobe_len", wr_run, 4);
        wr_run = 0;
      end
      if (!usb_pktend) begin
        chk("pe_addr", 32'(usb_fifoaddr), 2);
        pe_run++;
        if (pe_run == 4) begin
          pe_cnt++;
          serve = {serve, "P"};
        end
      end else if (pe_run != 0) begin
        chk("pe_strobe_len", pe_run, 4);
        last_pe_len = pe_run;
        pe_run = 0;
      end
      if (tx_valid && tx_room) m_tx.push_back(tx_data);
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      quiet = 8;
      prev_drv = 0;
    end else begin
      chk("rx_valid", 32'(rx_valid), 32'(m_rx.size() != 0));
      if (m_rx.size() != 0) chk("rx_data", 32'(rx_data), 32'(m_rx[0]));
      chk("rx_level", 32'(rx_level), m_rx.size());
      chk("tx_level", 32'(tx_level), m_tx.size());
      chk("tx_ready", 32'(tx_ready), 32'(m_tx.size() < D));
      chk("slcs", 32'(usb_slcs), 0);
      chk("one_strobe", 32'(int'(!usb_slrd) + int'(!usb_slwr) + int'(!usb_pktend) <= 1), 1);
      if (!usb_sloe) begin
        chk("fd_fx2_only", 32'(usb_fd), 32'(ep2_mem[ep2_rd]));
        chk("sloe_vs_slwr", 32'(usb_slwr), 1);
      end
      drv = usb_sloe && usb_fd != 16'hFFFF;
      if (drv && !prev_drv) chk("turnaround_idle", 32'(quiet >= 2), 1);
      quiet = (usb_sloe && !drv) ? quiet + 1 : 0;
      prev_drv = drv;
    end
  end

  task automatic do_reset();
    ep2_n = 0; tx_valid = 0; tx_flush = 0; rx_ready = 0; usb_flagc = 0;
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
  endtask

  task automatic push_tx(input logic [15:0] w);
    tx_data = w; tx_valid = 1;
    @(negedge clk);
    tx_valid = 0;
  endtask

  task automatic pulse_flush();
    tx_flush = 1;
    @(negedge clk);
    tx_flush = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ep2_mem[i] = 16'h2000 + 16'(i);
    repeat (2) @(negedge clk);
    chk("rst_slrd", 32'(usb_slrd), 1);
    chk("rst_slwr", 32'(usb_slwr), 1);
    chk("rst_sloe", 32'(usb_sloe), 1);
    chk("rst_pktend", 32'(usb_pktend), 1);
    chk("rst_fifoaddr", 32'(usb_fifoaddr), 0);
    chk("rst_fd_released", 32'(usb_fd), 32'hFFFF);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_tx_ready", 32'(tx_ready), 1);
    chk("rst_levels", {rx_level, tx_level}, 0);
    do_reset();
    // reset in the middle of a write strobe
    usb_flagc = 1;
    push_tx(16'h1111);
    for (int i = 0; i < 40 && usb_slwr; i++) @(negedge clk);
    chk("t1_slwr_seen", 32'(usb_slwr), 0);
    @(posedge clk);
    #1 reset = 1;
    #1;
    chk("t1_slwr_rel", 32'(usb_slwr), 1);
    chk("t1_fd_z", 32'(usb_fd), 32'hFFFF);
    chk("t1_tx_level", 32'(tx_level), 0);
    chk("t1_no_ep6", wr_cnt, 0);
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (20) @(negedge clk);
    chk("t1_no_ep6_after", wr_cnt, 0);
    // loopback of two EP2 words
    do_reset();
    ep2_mem[0] = 16'h1234; ep2_mem[1] = 16'hABCD;
    rx_ready = 1; ep2_n = 2;
    for (int i = 0; i < 80 && rx_popped.size() < 2; i++) @(negedge clk);
    chk("t2_pop_count", rx_popped.size(), 2);
    if (rx_popped.size() == 2) begin
      chk("t2_word0", 32'(rx_popped[0]), 32'h1234);
      chk("t2_word1", 32'(rx_popped[1]), 32'hABCD);
    end
    chk("t2_slrd_len", last_rd_len, 4);
    chk("t2_rd_cnt", rd_cnt, 2);
    // RX back-pressure
    do_reset();
    for (int i = 0; i < 32; i++) ep2_mem[i] = 16'h3000 + 16'(i);
    ep2_n = 20;
    for (int i = 0; i < 220 && rd_cnt < 16; i++) @(negedge clk);
    repeat (40) @(negedge clk);
    chk("t3_rd_cnt", rd_cnt, 16);
    chk("t3_rx_level", 32'(rx_level), 16);
    chk("t3_rx_valid", 32'(rx_valid), 1);
    chk("t3_slrd_idle", 32'(usb_slrd), 1);
    rx_ready = 1;
    for (int i = 0; i < 300 && (rd_cnt < 20 || rx_popped.size() < 20); i++) @(negedge clk);
    chk("t3_total_pops", rx_popped.size(), 20);
    if (rx_popped.size() == 20) begin
      chk("t3_first", 32'(rx_popped[0]), 32'h3000);
      chk("t3_last", 32'(rx_popped[19]), 32'h3013);
    end
    // arbitration between directions
    do_reset();
    for (int i = 0; i < 3; i++) ep2_mem[i] = 16'h5001 + 16'(i);
    push_tx(16'hA001); push_tx(16'hA002); push_tx(16'hA003);
    rx_ready = 1; usb_flagc = 1; ep2_n = 3;
    for (int i = 0; i < 150 && serve.len() < 6; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk_str("t4_order", serve, "RWRWRW");
    chk("t4_ep6_count", ep6.size(), 3);
    if (ep6.size() == 3) begin
      chk("t4_ep6_0", 32'(ep6[0]), 32'hA001);
      chk("t4_ep6_2", 32'(ep6[2]), 32'hA003);
    end
    chk("t4_rx_pops", rx_popped.size(), 3);
    // flush with a double pulse, then a zero-length packet
    do_reset();
    for (int i = 0; i < 5; i++) push_tx(16'hB001 + 16'(i));
    pulse_flush();
    repeat (2) @(negedge clk);
    pulse_flush();
    usb_flagc = 1;
    for (int i = 0; i < 150 && pe_cnt < 1; i++) @(negedge clk);
    repeat (30) @(negedge clk);
    chk_str("t5_order", serve, "WWWWWP");
    chk("t5_pe_cnt", pe_cnt, 1);
    chk("t5_pe_len", last_pe_len, 4);
    if (ep6.size() == 5) chk("t5_ep6_last", 32'(ep6[4]), 32'hB005);
    pulse_flush();
    for (int i = 0; i < 40 && pe_cnt < 2; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk_str("t5_zlp", serve, "WWWWWPP");
    // TX full with EP6 full
    do_reset();
    tx_valid = 1;
    for (int i = 0; i < 20; i++) begin
      tx_data = 16'hC000 + 16'(i);
      @(negedge clk);
    end
    tx_valid = 0;
    chk("t6_tx_level", 32'(tx_level), 16);
    chk("t6_tx_ready", 32'(tx_ready), 0);
    chk("t6_no_slwr", wr_cnt, 0);
    usb_flagc = 1;
    for (int i = 0; i < 250 && wr_cnt < 16; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    chk("t6_wr_cnt", wr_cnt, 16);
    if (ep6.size() == 16) begin
      chk("t6_ep6_first", 32'(ep6[0]), 32'hC000);
      chk("t6_ep6_last", 32'(ep6[15]), 32'hC00F);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
